// File: rtl/game_sequencer.sv
// Round controller for the calculator game: sequences generator requests, times the
// answer window, scores answers and tracks lives and level progression.
module game_sequencer #(
  parameter int TIME_LIMIT       = 500,
  parameter int LIVES            = 3,
  parameter int ROUNDS_PER_LEVEL = 4,
  parameter int MAX_LEVEL        = 5,
  parameter int SCORE_MAX        = 9999
) (
  input  logic        tick,
  input  logic        rst_n,
  input  logic        start,
  input  logic        answer_valid,
  input  logic [13:0] answer,
  input  logic        gen_done,
  input  logic [13:0] gen_result,
  output logic [3:0]  gen_state,
  output logic [2:0]  level,
  output logic [27:0] counter,
  output logic [13:0] score,
  output logic [2:0]  lives,
  output logic [15:0] timer,
  output logic        correct,
  output logic        wrong,
  output logic        game_over
);

  localparam int RW = (ROUNDS_PER_LEVEL > 1) ? $clog2(ROUNDS_PER_LEVEL) : 1;

  typedef enum logic [3:0] {
    S_IDLE      = 4'b0000,
    S_GEN       = 4'b0001,
    S_ANSWER    = 4'b0010,
    S_CHECK     = 4'b0011,
    S_LEVEL_UP  = 4'b0100,
    S_GAME_OVER = 4'b0101
  } state_e;

  state_e        state_q;
  logic [2:0]    level_q;
  logic [27:0]   counter_q;
  logic [13:0]   score_q;
  logic [2:0]    lives_q;
  logic [15:0]   timer_q;
  logic          correct_q;
  logic          wrong_q;
  logic          game_over_q;
  logic [RW-1:0] round_cnt_q;
  logic [13:0]   expected_q;
  logic [13:0]   answer_q;
  logic          timeout_q;

  logic [13:0]   score_d;
  logic          answer_ok_d;
  logic          round_last_d;
  logic          level_below_max_d;

  function automatic logic [13:0] sat_add(input logic [13:0] a, input logic [2:0] b);
    logic [14:0] s;
    s = {1'b0, a} + {12'd0, b};
    return (s > 15'(SCORE_MAX)) ? 14'(SCORE_MAX) : s[13:0];
  endfunction

  assign score_d           = sat_add(score_q, level_q);
  assign answer_ok_d       = !timeout_q && (answer_q == expected_q);
  assign round_last_d      = (round_cnt_q == RW'(ROUNDS_PER_LEVEL - 1));
  assign level_below_max_d = (level_q < 3'(MAX_LEVEL));

  // Round FSM with all game registers and registered outputs.
  always_ff @(posedge tick or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      level_q     <= 3'd1;
      counter_q   <= 28'd0;
      score_q     <= 14'd0;
      lives_q     <= 3'(LIVES);
      timer_q     <= 16'd0;
      correct_q   <= 1'b0;
      wrong_q     <= 1'b0;
      game_over_q <= 1'b0;
      round_cnt_q <= '0;
      expected_q  <= 14'd0;
      answer_q    <= 14'd0;
      timeout_q   <= 1'b0;
    end else begin
      counter_q <= counter_q + 28'd1;
      correct_q <= 1'b0;
      wrong_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            score_q     <= 14'd0;
            lives_q     <= 3'(LIVES);
            level_q     <= 3'd1;
            round_cnt_q <= '0;
            state_q     <= S_GEN;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_GEN: begin
          if (gen_done) begin
            expected_q <= gen_result;
            timer_q    <= 16'(TIME_LIMIT);
            timeout_q  <= 1'b0;
            state_q    <= S_ANSWER;
          end else begin
            state_q <= S_GEN;
          end
        end
        S_ANSWER: begin
          // A valid answer takes priority over expiry on the last window cycle.
          if (answer_valid) begin
            answer_q <= answer;
            timer_q  <= 16'd0;
            state_q  <= S_CHECK;
          end else if (timer_q == 16'd1) begin
            timer_q   <= 16'd0;
            timeout_q <= 1'b1;
            state_q   <= S_CHECK;
          end else begin
            timer_q <= timer_q - 16'd1;
            state_q <= S_ANSWER;
          end
        end
        S_CHECK: begin
          if (answer_ok_d) begin
            correct_q <= 1'b1;
            score_q   <= score_d;
            if (round_last_d && level_below_max_d) begin
              state_q <= S_LEVEL_UP;
            end else begin
              if (!round_last_d) begin
                round_cnt_q <= round_cnt_q + RW'(1);
              end else begin
                round_cnt_q <= round_cnt_q;
              end
              state_q <= S_GEN;
            end
          end else begin
            wrong_q <= 1'b1;
            if (lives_q <= 3'd1) begin
              lives_q     <= 3'd0;
              game_over_q <= 1'b1;
              state_q     <= S_GAME_OVER;
            end else begin
              lives_q <= lives_q - 3'd1;
              state_q <= S_GEN;
            end
          end
        end
        S_LEVEL_UP: begin
          level_q     <= level_q + 3'd1;
          round_cnt_q <= '0;
          state_q     <= S_GEN;
        end
        S_GAME_OVER: begin
          if (start) begin
            score_q     <= 14'd0;
            lives_q     <= 3'(LIVES);
            level_q     <= 3'd1;
            round_cnt_q <= '0;
            game_over_q <= 1'b0;
            state_q     <= S_GEN;
          end else begin
            game_over_q <= 1'b1;
            state_q     <= S_GAME_OVER;
          end
        end
        default: begin
          game_over_q <= 1'b0;
          timer_q     <= 16'd0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign gen_state = state_q;
  assign level     = level_q;
  assign counter   = counter_q;
  assign score     = score_q;
  assign lives     = lives_q;
  assign timer     = timer_q;
  assign correct   = correct_q;
  assign wrong     = wrong_q;
  assign game_over = game_over_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: a hand-computed round table, then random rounds scored
// by a per-round game model, plus reset and idle/game-over corner sequences.
module tb_game_sequencer;

  localparam int TL   = 8;
  localparam int LV   = 3;
  localparam int RPL  = 2;
  localparam int MAXL = 2;
  localparam int SMAX = 5;

  logic        tick = 1'b0;
  logic        rst_n;
  logic        start;
  logic        answer_valid;
  logic [13:0] answer;
  logic        gen_done;
  logic [13:0] gen_result;
  logic [3:0]  gen_state;
  logic [2:0]  level;
  logic [27:0] counter;
  logic [13:0] score;
  logic [2:0]  lives;
  logic [15:0] timer;
  logic        correct;
  logic        wrong;
  logic        game_over;

  int checks = 0;
  int errors = 0;
  int ticks  = 0;

  typedef struct {
    logic [13:0] res;
    logic [13:0] ans;
    int          delay;
    bit          tmo;
    bit          exp_c;
    int          exp_score;
    int          exp_lives;
    int          exp_level;
    int          exp_next;
  } vec_t;

  vec_t tbl[9];

  game_sequencer #(
    .TIME_LIMIT(TL), .LIVES(LV), .ROUNDS_PER_LEVEL(RPL), .MAX_LEVEL(MAXL), .SCORE_MAX(SMAX)
  ) dut (
    .tick(tick), .rst_n(rst_n), .start(start), .answer_valid(answer_valid),
    .answer(answer), .gen_done(gen_done), .gen_result(gen_result),
    .gen_state(gen_state), .level(level), .counter(counter), .score(score),
    .lives(lives), .timer(timer), .correct(correct), .wrong(wrong),
    .game_over(game_over)
  );

  always #5 tick = ~tick;

  task automatic step();
    @(posedge tick);
    #1;
    ticks++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, 32'(gen_state), 32'd0);
    chk({tag, "_level"}, 32'(level), 32'd1);
    chk({tag, "_counter"}, 32'(counter), 32'd0);
    chk({tag, "_score"}, 32'(score), 32'd0);
    chk({tag, "_lives"}, 32'(lives), 32'(LV));
    chk({tag, "_timer"}, 32'(timer), 32'd0);
    chk({tag, "_correct"}, 32'(correct), 32'd0);
    chk({tag, "_wrong"}, 32'(wrong), 32'd0);
    chk({tag, "_game_over"}, 32'(game_over), 32'd0);
  endtask

  task automatic new_game();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_state", 32'(gen_state), 32'd1);
    chk("start_score", 32'(score), 32'd0);
    chk("start_lives", 32'(lives), 32'(LV));
    chk("start_level", 32'(level), 32'd1);
    chk("start_game_over", 32'(game_over), 32'd0);
  endtask

  task automatic play_round(input vec_t v, input int pre, input bit noise);
    chk("pre_gen_state", 32'(gen_state), 32'd1);
    for (int p = 0; p < pre; p++) begin
      start        = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      answer_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      answer       = 14'($urandom_range(0, 16383));
      step();
      start        = 1'b0;
      answer_valid = 1'b0;
      chk("gen_hold", 32'(gen_state), 32'd1);
    end
    gen_result = v.res;
    gen_done   = 1'b1;
    step();
    gen_done   = 1'b0;
    gen_result = 14'($urandom_range(0, 16383));
    chk("answer_state", 32'(gen_state), 32'd2);
    chk("timer_load", 32'(timer), 32'(TL));
    if (v.tmo) begin
      for (int k = 1; k < TL; k++) begin
        start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        step();
        start = 1'b0;
        chk("timer_dec", 32'(timer), 32'(TL - k));
      end
      step();
    end else begin
      for (int k = 1; k <= v.delay; k++) begin
        start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        step();
        start = 1'b0;
        chk("timer_dec", 32'(timer), 32'(TL - k));
      end
      answer       = v.ans;
      answer_valid = 1'b1;
      step();
      answer_valid = 1'b0;
    end
    chk("check_state", 32'(gen_state), 32'd3);
    chk("check_timer", 32'(timer), 32'd0);
    chk("check_no_pulse", 32'({correct, wrong}), 32'd0);
    step();
    chk("correct", 32'(correct), 32'(v.exp_c));
    chk("wrong", 32'(wrong), 32'(!v.exp_c));
    chk("score", 32'(score), 32'(v.exp_score));
    chk("lives", 32'(lives), 32'(v.exp_lives));
    chk("next_state", 32'(gen_state), 32'(v.exp_next));
    if (v.exp_next == 4) begin
      step();
      chk("level_up_exit", 32'(gen_state), 32'd1);
      chk("pulse_one_cycle", 32'({correct, wrong}), 32'd0);
    end
    chk("level", 32'(level), 32'(v.exp_level));
    chk("game_over", 32'(game_over), 32'(v.exp_next == 5));
    chk("counter", 32'(counter), 32'(ticks[27:0]));
  endtask

  task automatic game_over_hold(input int exp_score, input int exp_level);
    for (int k = 0; k < 3; k++) begin
      gen_done     = 1'b1;
      answer_valid = 1'b1;
      step();
      gen_done     = 1'b0;
      answer_valid = 1'b0;
      chk("go_state", 32'(gen_state), 32'd5);
      chk("go_flag", 32'(game_over), 32'd1);
      chk("go_score", 32'(score), 32'(exp_score));
      chk("go_level", 32'(level), 32'(exp_level));
      chk("go_lives", 32'(lives), 32'd0);
    end
  endtask

  initial begin
    int score_m, lives_m, level_m, cnt_m;
    vec_t v;
    bit pick_ok;

    tbl[0] = '{14'd42,  14'd42,  1, 1'b0, 1'b1, 1, 3, 1, 1};
    tbl[1] = '{14'd100, 14'd100, 0, 1'b0, 1'b1, 2, 3, 2, 4};
    tbl[2] = '{14'd5,   14'd5,   3, 1'b0, 1'b1, 4, 3, 2, 1};
    tbl[3] = '{14'd9,   14'd0,   0, 1'b1, 1'b0, 4, 2, 2, 1};
    tbl[4] = '{14'd33,  14'd33,  7, 1'b0, 1'b1, 5, 2, 2, 1};
    tbl[5] = '{14'd9,   14'd7,   2, 1'b0, 1'b0, 5, 1, 2, 1};
    tbl[6] = '{14'd20,  14'd20,  0, 1'b0, 1'b1, 5, 1, 2, 1};
    tbl[7] = '{14'd20,  14'd20,  4, 1'b0, 1'b1, 5, 1, 2, 1};
    tbl[8] = '{14'd9,   14'd7,   5, 1'b0, 1'b0, 5, 0, 2, 5};

    rst_n = 1'b0; start = 1'b0; answer_valid = 1'b0; answer = 14'd0;
    gen_done = 1'b0; gen_result = 14'd0;
    step();
    step();
    chk_reset_vals("rst");
    rst_n = 1'b1;
    ticks = 0;

    for (int k = 0; k < 3; k++) begin
      answer_valid = 1'b1;
      answer       = 14'd0;
      gen_done     = 1'b1;
      step();
      answer_valid = 1'b0;
      gen_done     = 1'b0;
      chk("idle_ignore_state", 32'(gen_state), 32'd0);
      chk("idle_ignore_timer", 32'(timer), 32'd0);
      chk("idle_ignore_pulse", 32'({correct, wrong}), 32'd0);
    end
    chk("idle_counter", 32'(counter), 32'(ticks[27:0]));

    new_game();
    for (int i = 0; i < 9; i++) play_round(tbl[i], 0, 1'b0);
    game_over_hold(5, 2);
    new_game();

    score_m = 0; lives_m = LV; level_m = 1; cnt_m = 0;
    for (int r = 0; r < 40; r++) begin
      v.res   = 14'($urandom_range(0, 16383));
      v.tmo   = ($urandom_range(0, 6) == 0);
      pick_ok = ($urandom_range(0, 9) < 7);
      v.ans   = pick_ok ? v.res : (v.res ^ 14'($urandom_range(1, 16383)));
      v.delay = $urandom_range(0, TL - 1);
      v.exp_c = !v.tmo && (v.ans == v.res);
      if (v.exp_c) begin
        score_m = (score_m + level_m > SMAX) ? SMAX : score_m + level_m;
        cnt_m++;
        if (cnt_m >= RPL && level_m < MAXL) begin
          level_m++;
          cnt_m = 0;
          v.exp_next = 4;
        end else begin
          v.exp_next = 1;
        end
      end else begin
        lives_m--;
        v.exp_next = (lives_m == 0) ? 5 : 1;
      end
      v.exp_score = score_m;
      v.exp_lives = lives_m;
      v.exp_level = level_m;
      play_round(v, $urandom_range(0, 2), 1'b1);
      if (v.exp_next == 5) begin
        game_over_hold(score_m, level_m);
        new_game();
        score_m = 0; lives_m = LV; level_m = 1; cnt_m = 0;
      end
    end

    gen_result = 14'd77;
    gen_done   = 1'b1;
    step();
    gen_done   = 1'b0;
    step();
    step();
    chk("mid_answer_state", 32'(gen_state), 32'd2);
    chk("mid_answer_timer", 32'(timer), 32'(TL - 2));
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    step();
    chk_reset_vals("held_rst");
    rst_n = 1'b1;
    ticks = 0;
    for (int k = 0; k < 5; k++) step();
    chk("counter_after_5", 32'(counter), 32'd5);
    chk("idle_after_rst", 32'(gen_state), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
